// File: rtl/alu_control.sv
// ALU control decoder: maps (aluop, opcode, funct) to a registered 4-bit ALU select plus an illegal-decode flag.
// Optional build macro ALU_CONTROL_NOR_EN enables the R-type nor (funct 100111) decode.
module alu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] funct,
  input  logic [5:0] opcode,
  input  logic [1:0] aluop,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
`ifdef ALU_CONTROL_NOR_EN
  localparam logic [3:0] ALU_NOR = 4'b1100;
`endif

  logic [3:0] alucontrol_d, alucontrol_q;
  logic       illegal_d, illegal_q;

  // Every branch falls back to ADD/illegal; an X/Z selector never matches a
  // case item, so unknown inputs land on the defaults instead of propagating.
  always_comb begin
    alucontrol_d = ALU_ADD;
    illegal_d    = 1'b1;
    case (aluop)
      2'b00: begin
        alucontrol_d = ALU_ADD;
        illegal_d    = 1'b0;
      end
      2'b01: begin
        alucontrol_d = ALU_SUB;
        illegal_d    = 1'b0;
      end
      2'b10: begin
        case (opcode)
          6'b001000, 6'b001001: begin alucontrol_d = ALU_ADD; illegal_d = 1'b0; end
          6'b001100:            begin alucontrol_d = ALU_AND; illegal_d = 1'b0; end
          6'b001101:            begin alucontrol_d = ALU_OR;  illegal_d = 1'b0; end
          6'b001010, 6'b001011: begin alucontrol_d = ALU_SLT; illegal_d = 1'b0; end
          default:              begin alucontrol_d = ALU_ADD; illegal_d = 1'b1; end
        endcase
      end
      2'b11: begin
        case (funct)
          6'b100000, 6'b100001: begin alucontrol_d = ALU_ADD; illegal_d = 1'b0; end
          6'b100010, 6'b100011: begin alucontrol_d = ALU_SUB; illegal_d = 1'b0; end
          6'b100100:            begin alucontrol_d = ALU_AND; illegal_d = 1'b0; end
          6'b100101:            begin alucontrol_d = ALU_OR;  illegal_d = 1'b0; end
          6'b101010:            begin alucontrol_d = ALU_SLT; illegal_d = 1'b0; end
`ifdef ALU_CONTROL_NOR_EN
          6'b100111:            begin alucontrol_d = ALU_NOR; illegal_d = 1'b0; end
`endif
          default:              begin alucontrol_d = ALU_ADD; illegal_d = 1'b1; end
        endcase
      end
      default: begin
        alucontrol_d = ALU_ADD;
        illegal_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alucontrol_q <= 4'b0000;
      illegal_q    <= 1'b0;
    end else begin
      alucontrol_q <= alucontrol_d;
      illegal_q    <= illegal_d;
    end
  end

  assign alucontrol = alucontrol_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_control.sv
// Randomized and directed self-checking bench for alu_control against a table-driven reference model.
module tb_alu_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] funct;
  logic [5:0] opcode;
  logic [1:0] aluop;
  logic [3:0] alucontrol;
  logic       illegal;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;

  logic [4:0] last_exp;
  bit         have_prev = 1'b0;

  // Reference decode tables, keyed by field value.
  logic [3:0] itype_map [int];
  logic [3:0] rtype_map [int];

  always #5 clk = ~clk;

  alu_control dut (
    .clk        (clk),
    .reset      (reset),
    .funct      (funct),
    .opcode     (opcode),
    .aluop      (aluop),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got illegal=%b alucontrol=%b, expected illegal=%b alucontrol=%b",
               tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  function automatic logic [4:0] model(input logic rst, input logic [1:0] op,
                                       input logic [5:0] opc, input logic [5:0] fn);
    if (rst) return 5'b0_0000;
    if (op == 2'd0) return 5'b0_0010;
    if (op == 2'd1) return 5'b0_0110;
    if (op == 2'd2) begin
      if (itype_map.exists(int'(opc))) return {1'b0, itype_map[int'(opc)]};
      return 5'b1_0010;
    end
    if (rtype_map.exists(int'(fn))) return {1'b0, rtype_map[int'(fn)]};
    return 5'b1_0010;
  endfunction

  // Drive at the falling edge, confirm the output still holds the previous
  // result, then check the newly registered result just after the rising edge.
  task automatic apply(input string tag, input logic rst, input logic [1:0] op,
                       input logic [5:0] opc, input logic [5:0] fn);
    logic [4:0] exp;
    @(negedge clk);
    reset = rst; aluop = op; opcode = opc; funct = fn;
    #2;
    if (have_prev) check({tag, "_hold"}, {illegal, alucontrol}, last_exp);
    @(posedge clk);
    #1;
    exp = model(rst, op, opc, fn);
    check(tag, {illegal, alucontrol}, exp);
    n_txn++;
    $display("txn %0d %s: rst=%b aluop=%b opcode=%b funct=%b -> illegal=%b alucontrol=%b",
             n_txn, tag, rst, op, opc, fn, illegal, alucontrol);
    last_exp  = exp;
    have_prev = 1'b1;
  endtask

  initial begin
    logic [5:0] opc_list [7];
    logic [5:0] fn_list  [9];
    logic [4:0] nor_exp;

    itype_map[6'b001000] = 4'b0010;
    itype_map[6'b001001] = 4'b0010;
    itype_map[6'b001100] = 4'b0000;
    itype_map[6'b001101] = 4'b0001;
    itype_map[6'b001010] = 4'b0111;
    itype_map[6'b001011] = 4'b0111;
    rtype_map[6'b100000] = 4'b0010;
    rtype_map[6'b100001] = 4'b0010;
    rtype_map[6'b100010] = 4'b0110;
    rtype_map[6'b100011] = 4'b0110;
    rtype_map[6'b100100] = 4'b0000;
    rtype_map[6'b100101] = 4'b0001;
    rtype_map[6'b101010] = 4'b0111;
`ifdef ALU_CONTROL_NOR_EN
    rtype_map[6'b100111] = 4'b1100;
    nor_exp = 5'b0_1100;
`else
    nor_exp = 5'b1_0010;
`endif

    opc_list = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010, 6'b001011, 6'b001110};
    fn_list  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                 6'b100101, 6'b101010, 6'b100111, 6'b000000};

    reset = 1'b1; aluop = 2'b11; opcode = 6'b001110; funct = 6'b100111;

    // Reset with arbitrary inputs, then first decode after release.
    apply("reset0", 1'b1, 2'b11, 6'b001110, 6'b100111);
    apply("reset1", 1'b1, 2'b01, 6'b000100, 6'b100010);
    check("reset_const", {illegal, alucontrol}, 5'b0_0000);
    apply("lw_add", 1'b0, 2'b00, 6'b100011, 6'b000000);
    apply("beq_sub", 1'b0, 2'b01, 6'b000100, 6'b000000);
    apply("sw_add", 1'b0, 2'b00, 6'b101011, 6'b000000);

    apply("addi", 1'b0, 2'b10, 6'b001000, 6'b000000);
    apply("andi", 1'b0, 2'b10, 6'b001100, 6'b000000);
    apply("ori",  1'b0, 2'b10, 6'b001101, 6'b000000);
    apply("slti", 1'b0, 2'b10, 6'b001010, 6'b000000);
    apply("sltiu",1'b0, 2'b10, 6'b001011, 6'b000000);
    apply("xori", 1'b0, 2'b10, 6'b001110, 6'b000000);
    check("xori_illegal", {illegal, alucontrol}, 5'b1_0010);

    apply("add", 1'b0, 2'b11, 6'b000000, 6'b100000);
    apply("sub", 1'b0, 2'b11, 6'b000000, 6'b100010);
    apply("and", 1'b0, 2'b11, 6'b000000, 6'b100100);
    apply("or",  1'b0, 2'b11, 6'b000000, 6'b100101);
    apply("slt", 1'b0, 2'b11, 6'b000000, 6'b101010);
    apply("nor", 1'b0, 2'b11, 6'b000000, 6'b100111);
    check("nor_build", {illegal, alucontrol}, nor_exp);
    apply("funct0", 1'b0, 2'b11, 6'b000000, 6'b000000);

    // Reset in the same cycle as a valid SUB decode wins.
    apply("sub_pre", 1'b0, 2'b01, 6'b000100, 6'b000000);
    apply("rst_sub", 1'b1, 2'b01, 6'b000100, 6'b000000);
    check("rst_over_sub", {illegal, alucontrol}, 5'b0_0000);
    apply("resume", 1'b0, 2'b01, 6'b000100, 6'b000000);

    for (int i = 0; i < 300; i++) begin
      logic       r;
      logic [1:0] op;
      logic [5:0] opc, fn;
      r   = ($urandom_range(0, 49) == 0);
      op  = 2'($urandom_range(0, 3));
      opc = ($urandom_range(0, 1) == 0) ? opc_list[$urandom_range(0, 6)] : 6'($urandom);
      fn  = ($urandom_range(0, 1) == 0) ? fn_list[$urandom_range(0, 8)]  : 6'($urandom);
      apply("rand", r, op, opc, fn);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
